// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode handshake bundle for the fetch_queue instruction buffer
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [AW-1:0]            in_pc;
    logic [DW-1:0]            in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [AW-1:0]            out_pc;
    logic [DW-1:0]            out_instr;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - circular {PC, instruction} FIFO between fetch and decode with flush
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [AW+DW-1:0] head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass_take;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem[rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass      = empty && !bus.flush;
    // A pair consumed straight through the bypass never occupies a slot.
    assign bypass_take = bypass && bus.in_valid && bus.out_ready;

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        if (bypass) begin
            bus.out_valid = bus.in_valid;
            if (bus.in_valid) begin
                bus.out_pc    = bus.in_pc;
                bus.out_instr = bus.in_instr;
            end
        end else if (!empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = head[AW+DW-1:DW];
            bus.out_instr = head[DW-1:0];
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        if (!empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = head[AW+DW-1:DW];
            bus.out_instr = head[DW-1:0];
        end
    end
`endif

    // in_ready depends only on registered occupancy, so a same-cycle pop never frees a full queue.
    assign bus.in_ready = !full;
    assign bus.count    = count_q;

    assign push = bus.in_valid && !full && !bypass_take;
    assign pop  = !empty && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
        end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage (PC register, PC+4 adder, instruction memory) and the decode stage. Captures each fetched {PC, instruction} pair into a small circular FIFO with valid/ready handshakes on both sides. Decode can stall without stalling fetch until the queue fills. A flush input discards all buffered instructions on a redirect.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `AW`, 32, PC width
- `DW`, 32, instruction width
- `clk`  in  1  clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  fetch presents a valid pair
- `in_ready`  out  1  queue can accept a pair this cycle
- `in_pc`  in  AW  PC of the fetched instruction
- `in_instr`  in  DW  fetched instruction word
- `out_valid`  out  1  head entry is valid for decode
- `out_ready`  in  1  decode consumes the head this cycle
- `out_pc`  out  AW  PC of the head entry
- `out_instr`  out  DW  instruction at the head entry
- `flush`  in  1  discard all contents (branch/jump redirect)
- `count`  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: `DEPTH` × {AW+DW} array, with head pointer `rd_ptr`, tail pointer `wr_ptr` and occupancy register `count`.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- `in_ready` = (`count` < DEPTH). It is registered-state only and never depends on `out_ready`.
- Push occurs when `in_valid` & `in_ready`: the entry is written at `wr_ptr`, then `wr_ptr` increments.
- Pop occurs when `out_valid` & `out_ready`: `rd_ptr` increments.
- `out_valid` = (`count` != 0).
- `out_pc`/`out_instr` are a combinational read of entry `rd_ptr` when `count` != 0, and 0 when the queue is empty.
- Count update:
  - push and no pop: `count` increments.
  - pop and no push: `count` decrements.
  - both push and pop: `count` is unchanged. This is legal at any occupancy 1..DEPTH-1.
- When full, a push is impossible because `in_ready` = 0, even if a pop happens the same cycle. The freed slot is visible next cycle.
- `flush` has priority over everything. On the next edge, `rd_ptr`, `wr_ptr` and `count` all go to 0. Any push or pop in the flush cycle is discarded, and array contents are don't-care.
- Once `in_valid` and payload are presented, they are held stable until accepted. Fetch does not advance its PC while `in_ready` = 0.
- Values are unchanged between input and output; no arithmetic on PC or instruction.

## Timing
- Reset (async assert, sync release) drives:
  - `count` = 0 and both pointers = 0.
  - `out_valid` = 0 and `out_pc` = `out_instr` = 0.
  - `in_ready` = 1.
- Reset asserted mid-operation empties the queue immediately, with no edge needed. Content is lost.
- Latency without bypass: an entry pushed at edge N is visible on `out_*` with `out_valid` = 1 in the cycle after edge N. It can pop at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- `flush` is sampled at the edge. In the cycle after the flush edge, `out_valid` = 0 and `in_ready` = 1.
- `count` is registered and reflects state after the last edge.

## Configuration
- Macro: `FETCH_QUEUE_BYPASS_EN`.
- Defined: when `count` = 0 and `flush` = 0, the queue is transparent.
  - `out_valid` = `in_valid`, and `out_pc`/`out_instr` = `in_pc`/`in_instr` combinationally.
  - If `out_ready` = 1 in that cycle, the pair is consumed and not written, so `count` stays 0.
  - If `out_ready` = 0, the pair is written normally and `count` becomes 1.
  - Zero-cycle latency when empty.
- Undefined: no bypass. Minimum latency is one cycle, and `out_*` are driven from storage only.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle with 2 entries queued -> `out_valid` = 0, `count` = 0, `in_ready` = 1, and `out_pc` = 0 before the next edge.
- Fill/drain: push PCs 0x00, 0x04, 0x08, 0x0C with `out_ready` = 0.
  - Expected: `count` = 4 and `in_ready` = 0, and a 5th pair 0x10 is not accepted.
  - Then raise `out_ready`: PCs pop in order 0x00..0x0C, then 0x10 is accepted.
- Wrap-around: 10 cycles of simultaneous push/pop at `count` = 2 -> `count` stays 2, outputs show sequential PCs with no gaps or duplicates across pointer wrap 3→0.
- Flush: with 3 entries, assert `flush` together with `in_valid` (PC 0x40) and `out_ready`.
  - Expected: the next cycle has `count` = 0 and `out_valid` = 0, and PC 0x40 is not stored.
  - A following push of 0x80 is output first.
- Full boundary: `count` = 4, `out_ready` = 1, `in_valid` = 1 -> pop only, `count` = 3, then push accepted the next cycle.
- Bypass (macro defined): empty queue, `in_valid` with PC 0x20, `out_ready` = 1 -> `out_valid` = 1 and `out_pc` = 0x20 in the same cycle, with `count` still 0 after the edge. Without the macro -> `out_valid` = 0 that cycle and 0x20 appears the next cycle.
